// File: rtl/bomb_engine.sv
// Bomb timer / blast / damage engine for the BombMan arena.
// Holds per-cell fuse and owner state, resolves placements, ticks, chain
// reactions, player damage and the end-of-game decision.
module bomb_engine #(
  parameter int GRID_W      = 10,
  parameter int GRID_H      = 10,
  parameter int CRD         = 4,
  parameter int NUM_PLAYERS = 2,
  parameter int FUSE        = 3,
  parameter int RADIUS      = 2,
  parameter int MAX_BOMBS   = 2,
  parameter int MAX_HEALTH  = 3,
  localparam int HW         = $clog2(MAX_HEALTH + 1),
  localparam int PW         = $clog2(NUM_PLAYERS)
) (
  input  logic                       bombClk,
  input  logic                       rst_n,
  input  logic                       tick,
  input  logic [NUM_PLAYERS-1:0]     place_v,
  input  logic [NUM_PLAYERS*CRD-1:0] place_x,
  input  logic [NUM_PLAYERS*CRD-1:0] place_y,
  input  logic [NUM_PLAYERS*CRD-1:0] player_x,
  input  logic [NUM_PLAYERS*CRD-1:0] player_y,
  output logic [NUM_PLAYERS-1:0]     place_ack,
  output logic [GRID_W*GRID_H-1:0]   bomb_map,
  output logic [GRID_W*GRID_H-1:0]   blast_map,
  output logic                       blast_v,
  output logic [NUM_PLAYERS*HW-1:0]  health,
  output logic                       game_over,
  output logic                       draw,
  output logic [PW-1:0]              winner
);

  localparam int NC = GRID_W * GRID_H;
  localparam int FW = $clog2(FUSE + 1);
  localparam int CW = $clog2(MAX_BOMBS + 1);

  logic [NC-1:0][FW-1:0]          r_fuse;
  logic [NC-1:0][PW-1:0]          r_own;
  logic [NUM_PLAYERS-1:0][CW-1:0] r_cnt;
  logic [NUM_PLAYERS-1:0][HW-1:0] r_hp;
  logic [NUM_PLAYERS-1:0]         r_ack;
  logic [NC-1:0]                  r_blast;
  logic                           r_bv;
  logic                           r_go;
  logic                           r_draw;
  logic [PW-1:0]                  r_win;

  logic                           w_tick;
  logic [NC-1:0]                  w_expl;
  logic [NC-1:0]                  w_blast;
  logic [NC-1:0][FW-1:0]          w_fuse_n;
  logic [NC-1:0][PW-1:0]          w_own_n;
  logic [NUM_PLAYERS-1:0][CW-1:0] w_cnt_n;
  logic [NUM_PLAYERS-1:0][HW-1:0] w_hp_n;
  logic [NUM_PLAYERS-1:0]         w_ack;
  logic [NUM_PLAYERS-1:0]         w_hit;
  logic [NC-1:0]                  w_taken;
  int                             w_alive;
  logic [PW-1:0]                  w_first;

  // Ticks are frozen once the game has been decided.
  assign w_tick = tick & ~r_go;

  // Cells whose fuse runs out on this tick.
  always_comb begin
    w_expl = '0;
    for (int c = 0; c < NC; c++)
      w_expl[c] = w_tick && (r_fuse[c] == FW'(1));
  end

  // Blast crosses of all exploding bombs, clipped to the playable area.
  always_comb begin
    w_blast = '0;
    for (int x = 1; x < GRID_W - 1; x++)
      for (int y = 1; y < GRID_H - 1; y++)
        if (w_expl[x*GRID_H+y])
          for (int d = -RADIUS; d <= RADIUS; d++) begin
            if (x + d >= 1 && x + d <= GRID_W - 2) w_blast[(x+d)*GRID_H+y] = 1'b1;
            if (y + d >= 1 && y + d <= GRID_H - 2) w_blast[x*GRID_H+y+d] = 1'b1;
          end
  end

  // Tick first (explode / decrement / chain), then placements on top of it;
  // a cell is judged empty on its pre-tick fuse, lower player index wins ties.
  always_comb begin
    int px, py, c;
    w_fuse_n = r_fuse;
    w_own_n  = r_own;
    w_cnt_n  = r_cnt;
    w_ack    = '0;
    w_taken  = '0;
    px = 0;
    py = 0;
    c  = 0;
    for (int i = 0; i < NC; i++) begin
      if (w_expl[i]) begin
        w_fuse_n[i]         = '0;
        w_cnt_n[r_own[i]]   = w_cnt_n[r_own[i]] - CW'(1);
      end else if (w_tick && r_fuse[i] != '0) begin
        w_fuse_n[i] = w_blast[i] ? FW'(1) : r_fuse[i] - FW'(1);
      end
    end
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      px = int'(place_x[p*CRD +: CRD]);
      py = int'(place_y[p*CRD +: CRD]);
      if (place_v[p] && !r_go && r_hp[p] != '0 && r_cnt[p] < CW'(MAX_BOMBS) &&
          px >= 1 && px <= GRID_W - 2 && py >= 1 && py <= GRID_H - 2) begin
        c = px * GRID_H + py;
        if (r_fuse[c] == '0 && !w_taken[c]) begin
          w_taken[c]  = 1'b1;
          w_ack[p]    = 1'b1;
          w_fuse_n[c] = FW'(FUSE);
          w_own_n[c]  = PW'(p);
          w_cnt_n[p]  = w_cnt_n[p] + CW'(1);
        end
      end
    end
  end

  // One hit per tick at most, saturating at zero health.
  always_comb begin
    int hx, hy;
    hx = 0;
    hy = 0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      hx = int'(player_x[p*CRD +: CRD]);
      hy = int'(player_y[p*CRD +: CRD]);
      w_hit[p] = 1'b0;
      if (hx < GRID_W && hy < GRID_H) w_hit[p] = w_blast[hx*GRID_H+hy];
      w_hp_n[p] = (w_hit[p] && r_hp[p] != '0) ? r_hp[p] - HW'(1) : r_hp[p];
    end
  end

  // Survivor count and lowest surviving index from registered health.
  always_comb begin
    w_alive = 0;
    w_first = '0;
    for (int p = NUM_PLAYERS - 1; p >= 0; p--)
      if (r_hp[p] != '0) begin
        w_alive = w_alive + 1;
        w_first = PW'(p);
      end
  end

  // Arena state: fuses, owners, bomb counts, health, blast and ack outputs.
  always_ff @(posedge bombClk or negedge rst_n) begin
    if (!rst_n) begin
      r_fuse  <= '0;
      r_own   <= '0;
      r_cnt   <= '0;
      r_ack   <= '0;
      r_blast <= '0;
      r_bv    <= 1'b0;
      for (int p = 0; p < NUM_PLAYERS; p++) r_hp[p] <= HW'(MAX_HEALTH);
    end else begin
      r_fuse  <= w_fuse_n;
      r_own   <= w_own_n;
      r_cnt   <= w_cnt_n;
      r_ack   <= w_ack;
      r_blast <= w_blast;
      r_bv    <= |w_expl;
      r_hp    <= w_hp_n;
    end
  end

  // Game end latches one cycle after the health update and stays set.
  always_ff @(posedge bombClk or negedge rst_n) begin
    if (!rst_n) begin
      r_go   <= 1'b0;
      r_draw <= 1'b0;
      r_win  <= '0;
    end else if (!r_go) begin
      if (w_alive == 1) begin
        r_go  <= 1'b1;
        r_win <= w_first;
      end else if (w_alive == 0) begin
        r_go   <= 1'b1;
        r_draw <= 1'b1;
      end
    end
  end

  // Output packing.
  always_comb begin
    for (int c = 0; c < NC; c++) bomb_map[c] = (r_fuse[c] != '0);
    for (int p = 0; p < NUM_PLAYERS; p++) health[p*HW +: HW] = r_hp[p];
  end

  assign place_ack = r_ack;
  assign blast_map = r_blast;
  assign blast_v   = r_bv;
  assign game_over = r_go;
  assign draw      = r_draw;
  assign winner    = r_win;

endmodule

// File: tb/tb_bomb_engine.sv
// Scoreboard bench for bomb_engine (default parameters, 10x10 grid, 2 players).
module tb_bomb_engine;

  localparam int K_ACK = 0, K_BV = 1, K_BMAP = 2, K_HP = 3, K_BOMB = 4,
                 K_GO = 5, K_DRAW = 6, K_WIN = 7;

  logic        bombClk, rst_n, tick;
  logic [1:0]  place_v, place_ack;
  logic [7:0]  place_x, place_y, player_x, player_y;
  logic [99:0] bomb_map, blast_map;
  logic        blast_v, game_over, draw;
  logic [3:0]  health;
  logic [0:0]  winner;

  bomb_engine dut (
    .bombClk(bombClk), .rst_n(rst_n), .tick(tick),
    .place_v(place_v), .place_x(place_x), .place_y(place_y),
    .player_x(player_x), .player_y(player_y),
    .place_ack(place_ack), .bomb_map(bomb_map), .blast_map(blast_map),
    .blast_v(blast_v), .health(health), .game_over(game_over),
    .draw(draw), .winner(winner)
  );

  typedef struct {
    string       tag;
    int          kind;
    logic [99:0] val;
    int          due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  initial bombClk = 1'b0;
  always #5 bombClk = ~bombClk;
  always @(posedge bombClk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [99:0] obs, input logic [99:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [99:0] obs_of(input int kind);
    case (kind)
      K_ACK:   return 100'(place_ack);
      K_BV:    return 100'(blast_v);
      K_BMAP:  return blast_map;
      K_HP:    return 100'(health);
      K_BOMB:  return bomb_map;
      K_GO:    return 100'(game_over);
      K_DRAW:  return 100'(draw);
      default: return 100'(winner);
    endcase
  endfunction

  // Expected results are queued in due-cycle order and popped by the monitor.
  task automatic expect_(input string tag, input int kind, input logic [99:0] val, input int dly);
    exp_t e;
    int   i;
    e.tag = tag; e.kind = kind; e.val = val; e.due = cyc + dly;
    i = 0;
    while (i < q.size() && q[i].due <= e.due) i++;
    q.insert(i, e);
  endtask

  always @(negedge bombClk) begin
    exp_t e;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      chk(e.tag, obs_of(e.kind), e.val);
    end
  end

  function automatic logic [99:0] b(input int c);
    logic [99:0] r;
    r = '0;
    r[c] = 1'b1;
    return r;
  endfunction

  // Radius-2 cross clipped to the playable 1..8 range.
  function automatic logic [99:0] cb(input int x, input int y);
    logic [99:0] r;
    r = '0;
    for (int d = -2; d <= 2; d++) begin
      if (x + d >= 1 && x + d <= 8) r[(x+d)*10+y] = 1'b1;
      if (y + d >= 1 && y + d <= 8) r[x*10+y+d] = 1'b1;
    end
    return r;
  endfunction

  task automatic pos(input int x0, input int y0, input int x1, input int y1);
    player_x = {4'(x1), 4'(x0)};
    player_y = {4'(y1), 4'(y0)};
  endtask

  task automatic req(input int p, input int x, input int y);
    place_v[p]        = 1'b1;
    place_x[p*4 +: 4] = 4'(x);
    place_y[p*4 +: 4] = 4'(y);
  endtask

  task automatic go(input bit t);
    tick = t;
    @(negedge bombClk);
    tick    = 1'b0;
    place_v = '0;
  endtask

  task automatic pl(input logic [1:0] eack, input logic [99:0] ebomb);
    expect_("ack", K_ACK, 100'(eack), 1);
    expect_("bomb_map", K_BOMB, ebomb, 1);
    go(1'b0);
  endtask

  task automatic tk(input bit ebv, input logic [99:0] emap, input logic [99:0] ebomb,
                    input logic [3:0] eh);
    expect_("blast_v", K_BV, 100'(ebv), 1);
    expect_("blast_map", K_BMAP, emap, 1);
    expect_("bomb_map", K_BOMB, ebomb, 1);
    expect_("health", K_HP, 100'(eh), 1);
    expect_("ack_idle", K_ACK, '0, 1);
    go(1'b1);
    expect_("blast_v_clr", K_BV, '0, 1);
    expect_("blast_map_clr", K_BMAP, '0, 1);
    go(1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [99:0] t1map;
    logic [3:0]  hseq [4];
    rst_n = 1'b0; tick = 1'b0; place_v = '0; place_x = '0; place_y = '0;
    pos(8, 8, 3, 5);
    repeat (2) @(negedge bombClk);
    chk("rst_health", 100'(health), 100'(4'hF));
    chk("rst_bomb_map", bomb_map, '0);
    chk("rst_game_over", 100'(game_over), '0);
    chk("rst_ack", 100'(place_ack), '0);
    rst_n = 1'b1;
    @(negedge bombClk);

    // Single bomb lifecycle; P1 standing in the blast.
    req(0, 3, 3); pl(2'b01, b(33));
    expect_("ack_pulse", K_ACK, '0, 1); go(1'b0);
    tk(1'b0, '0, b(33), 4'hF);
    tk(1'b0, '0, b(33), 4'hF);
    t1map = b(13) | b(23) | b(33) | b(43) | b(53) | b(31) | b(32) | b(34) | b(35);
    expect_("go_after_hit", K_GO, '0, 2);
    tk(1'b1, t1map, '0, 4'b1011);

    // Chain reaction; second bomb placed on the same edge as a tick.
    pos(8, 8, 8, 1);
    req(0, 3, 3); pl(2'b01, b(33));
    tk(1'b0, '0, b(33), 4'b1011);
    req(0, 3, 5);
    expect_("ack_on_tick", K_ACK, 100'(2'b01), 1);
    expect_("bomb_on_tick", K_BOMB, b(33) | b(35), 1);
    expect_("bv_on_tick", K_BV, '0, 1);
    go(1'b1);
    go(1'b0);
    tk(1'b1, cb(3, 3), b(35), 4'b1011);
    tk(1'b1, cb(3, 5), '0, 4'b1011);

    // Per-player bomb limit.
    req(0, 2, 2); pl(2'b01, b(22));
    req(0, 6, 6); pl(2'b01, b(22) | b(66));
    req(0, 2, 6); pl(2'b00, b(22) | b(66));
    tk(1'b0, '0, b(22) | b(66), 4'b1011);
    tk(1'b0, '0, b(22) | b(66), 4'b1011);
    tk(1'b1, cb(2, 2) | cb(6, 6), '0, 4'b1011);
    req(0, 2, 6); pl(2'b01, b(26));
    tk(1'b0, '0, b(26), 4'b1011);
    tk(1'b0, '0, b(26), 4'b1011);
    tk(1'b1, cb(2, 6), '0, 4'b1011);

    // Same-cell contention, border, occupied cell, owner bookkeeping.
    req(0, 4, 4); req(1, 4, 4); pl(2'b01, b(44));
    req(1, 0, 4); pl(2'b00, b(44));
    req(1, 4, 4); pl(2'b00, b(44));
    req(0, 5, 7); pl(2'b01, b(44) | b(57));
    req(0, 7, 2); pl(2'b00, b(44) | b(57));
    tk(1'b0, '0, b(44) | b(57), 4'b1011);
    tk(1'b0, '0, b(44) | b(57), 4'b1011);
    tk(1'b1, cb(4, 4) | cb(5, 7), '0, 4'b1011);
    req(0, 7, 2); pl(2'b01, b(72));
    req(0, 2, 7); pl(2'b01, b(72) | b(27));
    tk(1'b0, '0, b(72) | b(27), 4'b1011);
    tk(1'b0, '0, b(72) | b(27), 4'b1011);
    tk(1'b1, cb(7, 2) | cb(2, 7), '0, 4'b1011);

    // Overlapping blasts cost one health; then P1 dies and P0 wins.
    pos(8, 8, 3, 5);
    req(0, 3, 3); req(1, 5, 5); pl(2'b11, b(33) | b(55));
    tk(1'b0, '0, b(33) | b(55), 4'b1011);
    tk(1'b0, '0, b(33) | b(55), 4'b1011);
    expect_("go_still_0", K_GO, '0, 2);
    tk(1'b1, cb(3, 3) | cb(5, 5), '0, 4'b0111);
    req(0, 3, 3); pl(2'b01, b(33));
    tk(1'b0, '0, b(33), 4'b0111);
    tk(1'b0, '0, b(33), 4'b0111);
    expect_("go_win", K_GO, 100'(1'b1), 2);
    expect_("draw_win", K_DRAW, '0, 2);
    expect_("winner", K_WIN, '0, 2);
    tk(1'b1, cb(3, 3), '0, 4'b0011);
    expect_("go_sticky", K_GO, 100'(1'b1), 1);
    tk(1'b0, '0, '0, 4'b0011);
    req(0, 4, 4); pl(2'b00, '0);

    // Reset in the middle of a fuse.
    #2 rst_n = 1'b0;
    @(negedge bombClk);
    rst_n = 1'b1;
    req(0, 3, 3); pl(2'b01, b(33));
    tk(1'b0, '0, b(33), 4'hF);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_bomb_map", bomb_map, '0);
    chk("midrst_game_over", 100'(game_over), '0);
    chk("midrst_health", 100'(health), 100'(4'hF));
    @(negedge bombClk);
    rst_n = 1'b1;

    // Both players take the final hit on the same tick -> draw.
    pos(3, 4, 4, 3);
    hseq[0] = 4'hF; hseq[1] = 4'b1010; hseq[2] = 4'b0101; hseq[3] = 4'b0000;
    for (int r = 1; r <= 3; r++) begin
      req(0, 3, 3); pl(2'b01, b(33));
      tk(1'b0, '0, b(33), hseq[r-1]);
      tk(1'b0, '0, b(33), hseq[r-1]);
      expect_("go_draw", K_GO, 100'(r == 3), 2);
      expect_("draw", K_DRAW, 100'(r == 3), 2);
      tk(1'b1, cb(3, 3), '0, hseq[r]);
    end

    repeat (4) @(negedge bombClk);
    chk("sb_drain", 100'(q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
